onc_16_boot_ctrl: RTL and testbench
===================================

// Module: onc_16_boot_ctrl
// PURPOSE
//  Boot/program-load sequencer for the onc_16 core. Holds the CPU in reset, accepts a stream of
//  instruction words over a valid/ready port, writes them into instruction memory from LOAD_BASE
//  upward, then releases the CPU after a settle delay. Sits between a host loader and imem/CPU.
// PARAMETERS
//  ADDR_W         16   imem address width (matches core DATA_W)
//  WORD_W         16   instruction word width (matches core INST_W)
//  LOAD_BASE      0    first imem address written
//  RELEASE_DELAY  2    cycles (>=1) between the last-word write and CPU release
// PORTS
//  clock       in   1       system clock, rising edge
//  n_rst       in   1       asynchronous active-low reset
//  start       in   1       one-cycle pulse: begin (re)load
//  load_valid  in   1       load_data/load_last valid
//  load_data   in   WORD_W  instruction word
//  load_last   in   1       marks final program word
//  load_ready  out  1       controller accepts a beat
//  imem_we     out  1       imem write strobe
//  imem_waddr  out  ADDR_W  imem write address
//  imem_wdata  out  WORD_W  imem write data
//  cpu_n_rst   out  1       reset to core, active-low
//  busy        out  1       high in LOAD/SETTLE
//  done        out  1       high in RUN
//  err         out  1       high in ERR
//  word_cnt    out  ADDR_W  program words written this load
// BEHAVIOUR
//  Reset: state IDLE; load_ready=0, imem_we=0, imem_waddr=LOAD_BASE, imem_wdata=0, cpu_n_rst=0,
//   busy=0, done=0, err=0, word_cnt=0. All outputs registered. Reset mid-load aborts;
//   the partial imem contents are undefined.
//  States: IDLE, LOAD, SETTLE, RUN, ERR.
//  IDLE: start -> LOAD; the write pointer is set to LOAD_BASE and word_cnt to 0.
//  LOAD: load_ready=1. A beat is accepted on a clock edge where load_valid&load_ready=1.
//   For an accepted beat, the next cycle has imem_we=1 for exactly one cycle, imem_waddr=ptr,
//   and imem_wdata=load_data. Then ptr and word_cnt each increment by 1.
//   Full throughput is 1 beat/cycle. A low load_valid causes no write and no pointer change.
//   Accepted beat with load_last=1: load_ready=0 from the next cycle; go to SETTLE.
//   Accepted non-last beat at ptr=2**ADDR_W-1 (wrap): that word is written, then state goes
//   to ERR. Wrap-around is never silent.
//   start during LOAD or SETTLE is ignored.
//  SETTLE: cpu_n_rst=0; counts RELEASE_DELAY cycles, then RUN. cpu_n_rst first reads 1 exactly
//   RELEASE_DELAY+1 edges after the edge that accepted the last beat.
//  RUN: cpu_n_rst=1, done=1, busy=0. start -> cpu_n_rst=0 and done=0 on the next edge; enters
//   LOAD with ptr=LOAD_BASE and word_cnt=0 (reload).
//  ERR: cpu_n_rst=0, err=1, load_ready=0. start clears err and enters LOAD as from IDLE.
//  start and load_valid in the same IDLE cycle: only start acts; the beat is not accepted
//   because load_ready=0.
// CONFIGURATION
//  BOOT_CKSUM_EN defined: the controller keeps a WORD_W-bit modular sum of all program words.
//   After the load_last beat, load_ready stays 1 for one extra beat. That beat is a checksum,
//   is not written to imem, and does not count in word_cnt.
//   Checksum equals the sum -> SETTLE. Mismatch -> ERR.
//  BOOT_CKSUM_EN undefined: no sum logic; SETTLE is entered directly after the load_last beat.
// TESTING
//  1 Assert n_rst=0 mid-stream -> all outputs at reset values immediately (async); start then
//    reloads from LOAD_BASE.
//  2 start; beats 0x1234,0x5678,0x9ABC(last) on consecutive cycles -> imem_we pulses at
//    addr 0,1,2 with those data; word_cnt=3; cpu_n_rst=1 and done=1 exactly 3 edges after the
//    last accept.
//  3 Same stream with 2-cycle valid gaps -> no extra writes; addresses stay contiguous 0,1,2.
//  4 ADDR_W=4: 16 beats without last -> 16 writes, err=1, cpu_n_rst stays 0.
//    Then start -> err=0 and load resumes at addr 0.
//  5 In RUN, pulse start -> cpu_n_rst=0 next edge; new stream overwrites from LOAD_BASE.
//  6 BOOT_CKSUM_EN: words 0x0001,0x0002(last) + checksum 0x0003 -> done=1, only 2 writes.
//    Checksum 0x0004 instead -> err=1, cpu_n_rst=0.

Source files
------------

// File: rtl/onc_16_boot_ctrl_if.sv
// Program-load stream between a host loader and the onc_16 boot controller.
// The host (master) presents words with valid/last; the controller (slave) returns ready.
interface onc_16_boot_ctrl_if #(
    parameter int WORD_W = 16
);
    logic              load_valid;
    logic [WORD_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;

    modport master (
        output load_valid,
        output load_data,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_last,
        output load_ready
    );
endinterface

// File: rtl/onc_16_boot_ctrl.sv
// Boot sequencer for onc_16: holds the core in reset, streams words into imem, then releases it.
// Define BOOT_CKSUM_EN to require a trailing modular-sum checksum beat after the last word.
module onc_16_boot_ctrl #(
    parameter int ADDR_W        = 16,
    parameter int WORD_W        = 16,
    parameter int LOAD_BASE     = 0,
    parameter int RELEASE_DELAY = 2
) (
    input  logic              clock,
    input  logic              n_rst,
    input  logic              start,
    onc_16_boot_ctrl_if.slave load,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_n_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] word_cnt
);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(LOAD_BASE);
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;
    localparam int                CNT_W   = $clog2(RELEASE_DELAY + 1);
    localparam logic [CNT_W-1:0]  CNT_END = CNT_W'(RELEASE_DELAY);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
`ifdef BOOT_CKSUM_EN
        ST_CKSUM,
`endif
        ST_SETTLE,
        ST_RUN,
        ST_ERR
    } state_t;

    state_t             state_reg;
    logic [ADDR_W-1:0]  ptr_reg;
    logic [CNT_W-1:0]   settle_cnt_reg;
`ifdef BOOT_CKSUM_EN
    logic [WORD_W-1:0]  sum_reg;
`endif
    logic               accept;

    assign accept = load.load_valid & load.load_ready;

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state_reg       <= ST_IDLE;
            ptr_reg         <= BASE;
            settle_cnt_reg  <= '0;
            load.load_ready <= 1'b0;
            imem_we         <= 1'b0;
            imem_waddr      <= BASE;
            imem_wdata      <= '0;
            cpu_n_rst       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            word_cnt        <= '0;
`ifdef BOOT_CKSUM_EN
            sum_reg         <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state_reg)
                // IDLE, RUN and ERR all (re)start a load the same way.
                ST_IDLE, ST_RUN, ST_ERR: begin
                    if (start) begin
                        state_reg       <= ST_LOAD;
                        ptr_reg         <= BASE;
                        word_cnt        <= '0;
                        load.load_ready <= 1'b1;
                        busy            <= 1'b1;
                        cpu_n_rst       <= 1'b0;
                        done            <= 1'b0;
                        err             <= 1'b0;
`ifdef BOOT_CKSUM_EN
                        sum_reg         <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        imem_we    <= 1'b1;
                        imem_waddr <= ptr_reg;
                        imem_wdata <= load.load_data;
                        ptr_reg    <= ptr_reg + 1'b1;
                        word_cnt   <= word_cnt + 1'b1;
`ifdef BOOT_CKSUM_EN
                        sum_reg    <= sum_reg + load.load_data;
`endif
                        if (load.load_last) begin
`ifdef BOOT_CKSUM_EN
                            state_reg       <= ST_CKSUM;
`else
                            state_reg       <= ST_SETTLE;
                            settle_cnt_reg  <= '0;
                            load.load_ready <= 1'b0;
`endif
                        end else if (ptr_reg == PTR_MAX) begin
                            // The top address is still written; only the wrap itself is fatal.
                            state_reg       <= ST_ERR;
                            load.load_ready <= 1'b0;
                            busy            <= 1'b0;
                            err             <= 1'b1;
                        end
                    end
                end
`ifdef BOOT_CKSUM_EN
                ST_CKSUM: begin
                    if (accept) begin
                        load.load_ready <= 1'b0;
                        if (load.load_data == sum_reg) begin
                            state_reg      <= ST_SETTLE;
                            settle_cnt_reg <= '0;
                        end else begin
                            state_reg <= ST_ERR;
                            busy      <= 1'b0;
                            err       <= 1'b1;
                        end
                    end
                end
`endif
                ST_SETTLE: begin
                    if (settle_cnt_reg == CNT_END) begin
                        state_reg <= ST_RUN;
                        cpu_n_rst <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_onc_16_boot_ctrl.sv
// Self-checking bench for onc_16_boot_ctrl (ADDR_W=4 so the address wrap is reachable).
// Cycle-exact vector table plus a write scoreboard fed by the beat driver.
module tb_onc_16_boot_ctrl;
    logic        clock = 1'b0;
    logic        n_rst;
    logic        start;
    logic        imem_we;
    logic [3:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic        cpu_n_rst;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  word_cnt;

    int checks = 0;
    int errors = 0;

    onc_16_boot_ctrl_if #(.WORD_W(16)) lif ();

    onc_16_boot_ctrl #(
        .ADDR_W(4), .WORD_W(16), .LOAD_BASE(0), .RELEASE_DELAY(2)
    ) dut (
        .clock(clock), .n_rst(n_rst), .start(start), .load(lif.slave),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_n_rst(cpu_n_rst), .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic start, valid; logic [15:0] data; logic last;
        logic ready, we; logic [3:0] waddr; logic [15:0] wdata;
        logic cpu, bsy, dn, er; logic [3:0] cnt;
    } vec_t;

    typedef struct { logic [3:0] addr; logic [15:0] data; } wr_t;

    wr_t         sb[$];
    logic        sb_on = 1'b0;
    logic [3:0]  ptr_m;
    logic [15:0] sum_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Every imem write must match the oldest expected write.
    always @(posedge clock) begin
        #1;
        if (sb_on && n_rst && imem_we) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {imem_waddr, imem_wdata}, 64'h0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("write", {imem_waddr, imem_wdata}, {e.addr, e.data});
                $display("write addr=%0h data=%04h expected addr=%0h data=%04h",
                         imem_waddr, imem_wdata, e.addr, e.data);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1; lif.load_valid = 1'b0; lif.load_last = 1'b0;
        ptr_m = 4'h0; sum_m = 16'h0;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clock);
            start = 1'b0; lif.load_valid = 1'b0; lif.load_last = 1'b0;
        end
    endtask

    // Present one beat; it is accepted on the edge after ready is seen high.
    task automatic beat(input logic [15:0] d, input logic l, input logic wr);
        int n;
        @(negedge clock);
        start = 1'b0; lif.load_valid = 1'b1; lif.load_data = d; lif.load_last = l;
        n = 0;
        while (!lif.load_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!lif.load_ready) begin
            check("beat_ready_timeout", 64'(lif.load_ready), 64'h1);
        end else if (wr) begin
            sb.push_back('{addr: ptr_m, data: d});
            ptr_m = ptr_m + 4'h1;
            sum_m = sum_m + d;
        end
    endtask

    task automatic cks();
`ifdef BOOT_CKSUM_EN
        beat(sum_m, 1'b0, 1'b0);
`endif
    endtask

    // Called right after the final beat is presented: release is 3 edges after its accept.
    task automatic expect_release(input logic [3:0] cnt);
        gap(1);
        for (int e = 1; e <= 3; e++) begin
            @(posedge clock); #1;
            check($sformatf("release_edge%0d", e), {cpu_n_rst, done, busy},
                  (e == 3) ? 3'b110 : 3'b001);
        end
        check("word_cnt", word_cnt, cnt);
        check("sb_drained", sb.size(), 0);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b1,1'b0,16'h0000,1'b0, 1'b1,1'b0,4'h0,16'h0000,1'b0,1'b1,1'b0,1'b0,4'h0};
        tbl[1] = '{1'b0,1'b1,16'h1234,1'b0, 1'b1,1'b1,4'h0,16'h1234,1'b0,1'b1,1'b0,1'b0,4'h1};
        tbl[2] = '{1'b0,1'b1,16'h5678,1'b0, 1'b1,1'b1,4'h1,16'h5678,1'b0,1'b1,1'b0,1'b0,4'h2};
        tbl[3] = '{1'b0,1'b1,16'h9ABC,1'b1, 1'b0,1'b1,4'h2,16'h9ABC,1'b0,1'b1,1'b0,1'b0,4'h3};
        tbl[4] = '{1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,4'h2,16'h9ABC,1'b0,1'b1,1'b0,1'b0,4'h3};
        tbl[5] = '{1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,4'h2,16'h9ABC,1'b0,1'b1,1'b0,1'b0,4'h3};
        tbl[6] = '{1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,4'h2,16'h9ABC,1'b1,1'b0,1'b1,1'b0,4'h3};
        tbl[7] = '{1'b1,1'b0,16'h0000,1'b0, 1'b1,1'b0,4'h2,16'h9ABC,1'b0,1'b1,1'b0,1'b0,4'h0};

        n_rst = 1'b0; start = 1'b0;
        lif.load_valid = 1'b0; lif.load_data = 16'h0; lif.load_last = 1'b0;
        ptr_m = 4'h0; sum_m = 16'h0;
        repeat (2) @(negedge clock);
        check("reset_state",
              {lif.load_ready, imem_we, imem_waddr, imem_wdata, cpu_n_rst, busy, done, err, word_cnt},
              30'h0);
        n_rst = 1'b1;

`ifndef BOOT_CKSUM_EN
        // Three-word load, settle, release, then a reload from RUN.
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            start = tbl[i].start; lif.load_valid = tbl[i].valid;
            lif.load_data = tbl[i].data; lif.load_last = tbl[i].last;
            @(posedge clock); #1;
            check($sformatf("vec%0d", i),
                  {lif.load_ready, imem_we, imem_waddr, imem_wdata, cpu_n_rst, busy, done, err, word_cnt},
                  {tbl[i].ready, tbl[i].we, tbl[i].waddr, tbl[i].wdata, tbl[i].cpu,
                   tbl[i].bsy, tbl[i].dn, tbl[i].er, tbl[i].cnt});
            $display("vec%0d ready=%b we=%b addr=%0h data=%04h cpu_n_rst=%b done=%b cnt=%0d",
                     i, lif.load_ready, imem_we, imem_waddr, imem_wdata, cpu_n_rst, done, word_cnt);
        end
        ptr_m = 4'h0; sum_m = 16'h0;
`else
        pulse_start();
`endif
        sb_on = 1'b1;

        // Reload overwrites from the base address.
        beat(16'hAAAA, 1'b0, 1'b1);
        beat(16'hBBBB, 1'b1, 1'b1);
        cks();
        expect_release(4'd2);

        // Valid gaps: no extra writes, addresses stay contiguous.
        pulse_start();
        beat(16'h1234, 1'b0, 1'b1);
        gap(2);
        beat(16'h5678, 1'b0, 1'b1);
        gap(2);
        beat(16'h9ABC, 1'b1, 1'b1);
        cks();
        expect_release(4'd3);

        // Sixteen non-last beats wrap the 4-bit pointer.
        pulse_start();
        for (int i = 0; i < 16; i++) beat(16'h0100 + 16'(i), 1'b0, 1'b1);
        gap(1);
        check("wrap_state", {err, lif.load_ready, cpu_n_rst, busy, word_cnt}, {4'b1000, 4'h0});
        gap(2);
        check("wrap_hold", {err, cpu_n_rst, done}, 3'b100);
        check("wrap_writes", sb.size(), 0);
        pulse_start();
        @(posedge clock); #1;
        check("err_cleared", {err, lif.load_ready, busy}, 3'b011);
        beat(16'hCAFE, 1'b1, 1'b1);
        cks();
        expect_release(4'd1);

        // Asynchronous reset in the middle of a stream.
        pulse_start();
        beat(16'h1111, 1'b0, 1'b1);
        beat(16'h2222, 1'b0, 1'b1);
        @(posedge clock); #2;
        n_rst = 1'b0;
        #1;
        check("async_reset",
              {lif.load_ready, imem_we, imem_waddr, imem_wdata, cpu_n_rst, busy, done, err, word_cnt},
              30'h0);
        lif.load_valid = 1'b0;
        sb.delete();
        @(negedge clock);
        n_rst = 1'b1;
        pulse_start();
        beat(16'h3333, 1'b1, 1'b1);
        cks();
        expect_release(4'd1);

`ifdef BOOT_CKSUM_EN
        pulse_start();
        beat(16'h0001, 1'b0, 1'b1);
        beat(16'h0002, 1'b1, 1'b1);
        beat(16'h0003, 1'b0, 1'b0);
        expect_release(4'd2);
        pulse_start();
        beat(16'h0001, 1'b0, 1'b1);
        beat(16'h0002, 1'b1, 1'b1);
        beat(16'h0004, 1'b0, 1'b0);
        gap(1);
        check("cksum_bad", {err, cpu_n_rst, done, lif.load_ready}, 4'b1000);
        check("cksum_bad_writes", sb.size(), 0);
`endif

        gap(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
